// File: rtl/intersection_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : intersection_phase_arbiter
// Purpose  : Round-robin right-of-way sequencer for a 4-approach intersection
//            with min-green, yellow and all-red clearance and pre-emption.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_phase_arbiter #(
  parameter int MIN_GREEN  = 70,
  parameter int YELLOW_CYC = 25,
  parameter int ALLRED_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  has_car,
  input  logic        preempt,
  input  logic [1:0]  preempt_id,
  output logic [11:0] lights,
  output logic [1:0]  owner,
  output logic [1:0]  phase,
  output logic        switch_pulse
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;

  localparam logic [7:0] c_green_last  = 8'(MIN_GREEN - 1);
  localparam logic [7:0] c_yellow_last = 8'(YELLOW_CYC - 1);
  localparam logic [7:0] c_allred_last = 8'(ALLRED_CYC - 1);

  logic [1:0] r_phase, w_phase_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_next_owner, w_next_owner_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_pending, w_pending_nxt;
  logic       r_switch_pulse, w_switch_nxt;

  logic [3:0] w_owner_oh;
  logic [3:0] w_new_car;
  logic [3:0] w_req;
  logic       w_rr_valid;
  logic [1:0] w_rr_pick;

  assign w_owner_oh = 4'b0001 << r_owner;
  assign w_new_car  = has_car & ~w_owner_oh;
  assign w_req      = (r_pending | w_new_car) & ~w_owner_oh;

  // Scan downwards so the nearest approach after the owner is the last write.
  always_comb begin
    logic [1:0] idx;
    w_rr_valid = 1'b0;
    w_rr_pick  = r_owner;
    idx        = r_owner;
    for (int k = 3; k >= 1; k--) begin
      idx = r_owner + 2'(k);
      if (w_req[idx]) begin
        w_rr_valid = 1'b1;
        w_rr_pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= S_GREEN;
      r_owner        <= 2'd0;
      r_next_owner   <= 2'd0;
      r_cnt          <= 8'd0;
      r_pending      <= 4'd0;
      r_switch_pulse <= 1'b0;
    end else begin
      r_phase        <= w_phase_nxt;
      r_owner        <= w_owner_nxt;
      r_next_owner   <= w_next_owner_nxt;
      r_cnt          <= w_cnt_nxt;
      r_pending      <= w_pending_nxt;
      r_switch_pulse <= w_switch_nxt;
    end
  end

  always_comb begin
    w_phase_nxt      = r_phase;
    w_owner_nxt      = r_owner;
    w_next_owner_nxt = r_next_owner;
    w_cnt_nxt        = r_cnt;
    w_pending_nxt    = r_pending | w_new_car;
    w_switch_nxt     = 1'b0;
    case (r_phase)
      S_GREEN: begin
        if (preempt && (preempt_id != r_owner)) begin
          w_phase_nxt      = S_YELLOW;
          w_cnt_nxt        = 8'd0;
          w_next_owner_nxt = preempt_id;
        end else if (!preempt && (r_cnt >= c_green_last) && w_rr_valid) begin
          w_phase_nxt      = S_YELLOW;
          w_cnt_nxt        = 8'd0;
          w_next_owner_nxt = w_rr_pick;
        end else if (r_cnt < c_green_last) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_YELLOW: begin
        if (preempt) w_next_owner_nxt = preempt_id;
        if (r_cnt == c_yellow_last) begin
          w_phase_nxt = S_ALLRED;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ALLRED: begin
        if (preempt) w_next_owner_nxt = preempt_id;
        if (r_cnt == c_allred_last) begin
          // Clearing the new owner's request wins over a same-cycle arrival.
          w_phase_nxt   = S_GREEN;
          w_cnt_nxt     = 8'd0;
          w_owner_nxt   = w_next_owner_nxt;
          w_pending_nxt = w_pending_nxt & ~(4'b0001 << w_next_owner_nxt);
          w_switch_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_phase_nxt = S_GREEN;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    lights = {4{3'b100}};
    for (int i = 0; i < 4; i++) begin
      if (r_owner == 2'(i)) begin
        if (r_phase == S_GREEN)       lights[3*i +: 3] = 3'b001;
        else if (r_phase == S_YELLOW) lights[3*i +: 3] = 3'b010;
      end
    end
  end

  assign owner        = r_owner;
  assign phase        = r_phase;
  assign switch_pulse = r_switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_phase_arbiter
// Purpose  : Directed self-checking bench for intersection_phase_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  has_car = 4'd0;
  logic        preempt = 1'b0;
  logic [1:0]  preempt_id = 2'd0;
  logic [11:0] lights;
  logic [1:0]  owner;
  logic [1:0]  phase;
  logic        switch_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sp    = 0;

  // Lamp words: approach i occupies [3i+2:3i]
  localparam logic [11:0] L_G0 = 12'h921;  // 100_100_100_001
  localparam logic [11:0] L_Y0 = 12'h922;  // 100_100_100_010
  localparam logic [11:0] L_AR = 12'h924;  // 100_100_100_100
  localparam logic [11:0] L_G1 = 12'h90C;  // 100_100_001_100
  localparam logic [11:0] L_G2 = 12'h864;  // 100_001_100_100
  localparam logic [11:0] L_Y2 = 12'h8A4;  // 100_010_100_100
  localparam logic [11:0] L_G3 = 12'h324;  // 001_100_100_100

  intersection_phase_arbiter #(
    .MIN_GREEN (70),
    .YELLOW_CYC(25),
    .ALLRED_CYC(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .has_car     (has_car),
    .preempt     (preempt),
    .preempt_id  (preempt_id),
    .lights      (lights),
    .owner       (owner),
    .phase       (phase),
    .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nonred(input logic [11:0] l);
    int n = 0;
    for (int i = 0; i < 4; i++) if (l[3*i +: 3] != 3'b100) n++;
    return n;
  endfunction

  // Advance n cycles; every cycle checks the single-non-red-lamp rule.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (switch_pulse === 1'b1) sp++;
      chk("one_lamp", 32'(nonred(lights)), (phase == 2'd2) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic adv_to(input int t);
    adv(t - cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    has_car = 4'd0;
    preempt = 1'b0;
    preempt_id = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    sp = 0;
  endtask

  initial begin
    // 1: idle intersection keeps approach 0 green
    do_reset();
    chk("rst_lights", 32'(lights), 32'(L_G0));
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_sw", 32'(switch_pulse), 32'd0);
    for (int i = 0; i < 300; i++) begin
      adv(1);
      chk("t1_lights", 32'(lights), 32'(L_G0));
      chk("t1_sw", 32'(switch_pulse), 32'd0);
    end

    // 2: single pulse on approach 2
    do_reset();
    adv_to(10);
    has_car = 4'b0100;
    adv(1);
    has_car = 4'b0000;
    adv_to(69);
    chk("t2_green69", 32'(lights), 32'(L_G0));
    adv_to(70);
    chk("t2_yel70", 32'(lights), 32'(L_Y0));
    chk("t2_ph70", 32'(phase), 32'd1);
    adv_to(94);
    chk("t2_ph94", 32'(phase), 32'd1);
    adv_to(95);
    chk("t2_ar95", 32'(lights), 32'(L_AR));
    chk("t2_ph95", 32'(phase), 32'd2);
    adv_to(96);
    chk("t2_g96", 32'(lights), 32'(L_G2));
    chk("t2_own96", 32'(owner), 32'd2);
    chk("t2_sw96", 32'(switch_pulse), 32'd1);
    adv_to(97);
    chk("t2_sw97", 32'(switch_pulse), 32'd0);
    adv_to(250);
    chk("t2_own250", 32'(owner), 32'd2);
    chk("t2_spcnt", 32'(sp), 32'd1);

    // 3: cars held on 1 and 3 rotate 0,1,3,1,3
    do_reset();
    has_car = 4'b1010;
    adv_to(69);
    chk("t3_ph69", 32'(phase), 32'd0);
    adv_to(70);
    chk("t3_ph70", 32'(phase), 32'd1);
    adv_to(96);
    chk("t3_own96", 32'(owner), 32'd1);
    chk("t3_l96", 32'(lights), 32'(L_G1));
    adv_to(165);
    chk("t3_ph165", 32'(phase), 32'd0);
    adv_to(166);
    chk("t3_ph166", 32'(phase), 32'd1);
    adv_to(192);
    chk("t3_own192", 32'(owner), 32'd3);
    chk("t3_l192", 32'(lights), 32'(L_G3));
    adv_to(261);
    chk("t3_ph261", 32'(phase), 32'd0);
    adv_to(262);
    chk("t3_ph262", 32'(phase), 32'd1);
    adv_to(288);
    chk("t3_own288", 32'(owner), 32'd1);
    adv_to(384);
    chk("t3_own384", 32'(owner), 32'd3);
    chk("t3_spcnt", 32'(sp), 32'd4);

    // 4: pre-emption to 3 skips min-green, request on 1 waits
    do_reset();
    has_car = 4'b0010;
    adv(1);
    has_car = 4'b0000;
    adv_to(5);
    preempt = 1'b1;
    preempt_id = 2'd3;
    adv_to(6);
    preempt = 1'b0;
    chk("t4_y6", 32'(lights), 32'(L_Y0));
    adv_to(30);
    chk("t4_ph30", 32'(phase), 32'd1);
    adv_to(31);
    chk("t4_ar31", 32'(lights), 32'(L_AR));
    adv_to(32);
    chk("t4_own32", 32'(owner), 32'd3);
    chk("t4_l32", 32'(lights), 32'(L_G3));
    chk("t4_sw32", 32'(switch_pulse), 32'd1);
    adv_to(101);
    chk("t4_ph101", 32'(phase), 32'd0);
    adv_to(128);
    chk("t4_own128", 32'(owner), 32'd1);

    // 5: pre-emption during yellow redirects without shortening clearance
    do_reset();
    has_car = 4'b0010;
    adv(1);
    has_car = 4'b0000;
    adv_to(75);
    preempt = 1'b1;
    preempt_id = 2'd2;
    adv_to(76);
    preempt = 1'b0;
    adv_to(94);
    chk("t5_ph94", 32'(phase), 32'd1);
    adv_to(95);
    chk("t5_ph95", 32'(phase), 32'd2);
    adv_to(96);
    chk("t5_own96", 32'(owner), 32'd2);
    chk("t5_l96", 32'(lights), 32'(L_G2));
    adv_to(166);
    chk("t5_y166", 32'(lights), 32'(L_Y2));
    adv_to(192);
    chk("t5_own192", 32'(owner), 32'd1);
    chk("t5_l192", 32'(lights), 32'(L_G1));

    // 6: async reset in the middle of yellow
    do_reset();
    has_car = 4'b0100;
    adv(1);
    has_car = 4'b0000;
    adv_to(80);
    chk("t6_ph80", 32'(phase), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_l", 32'(lights), 32'(L_G0));
    chk("t6_rst_own", 32'(owner), 32'd0);
    chk("t6_rst_ph", 32'(phase), 32'd0);
    chk("t6_rst_sw", 32'(switch_pulse), 32'd0);
    do_reset();
    adv_to(120);
    chk("t6_lost", 32'(lights), 32'(L_G0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
